// File: rtl/watch_pkg.sv
// rtl/watch_pkg.sv - shared types and constants for the BCD time-of-day core
package watch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_SET   = 2'd3
  } tk_state_t;

  localparam logic [1:0] SEL_SEC  = 2'b00;
  localparam logic [1:0] SEL_MIN  = 2'b01;
  localparam logic [1:0] SEL_HR   = 2'b10;
  localparam logic [1:0] SEL_NONE = 2'b11;

  localparam int HOUR_MODE_12 = 12;
  localparam int HOUR_MODE_24 = 24;

  // 12-hour mode resets to 12:00:00 AM, 24-hour mode to 00:00:00
  localparam bcd_t RST_HR1_24 = 4'd0;
  localparam bcd_t RST_HR0_24 = 4'd0;
  localparam bcd_t RST_HR1_12 = 4'd1;
  localparam bcd_t RST_HR0_12 = 4'd2;
  localparam int   RST_MIN    = 0;
  localparam int   RST_SEC    = 0;

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter with modulus, clear and wrap carry
module bcd_mod_counter
  import watch_pkg::*;
#(
  parameter int MODULUS   = 60,
  parameter int RESET_VAL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clear,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic       carry
);

  localparam bcd_t MAX_D1 = bcd_t'((MODULUS - 1) / 10);
  localparam bcd_t MAX_D0 = bcd_t'((MODULUS - 1) % 10);
  localparam bcd_t RST_D1 = bcd_t'(RESET_VAL / 10);
  localparam bcd_t RST_D0 = bcd_t'(RESET_VAL % 10);

  logic at_max;

  assign at_max = (d1 == MAX_D1) && (d0 == MAX_D0);
  // carry is combinational so the next field advances on the same edge
  assign carry  = inc && at_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1 <= RST_D1;
      d0 <= RST_D0;
    end else if (clear) begin
      d1 <= 4'd0;
      d0 <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        d1 <= 4'd0;
        d0 <= 4'd0;
      end else if (d0 == 4'd9) begin
        d1 <= d1 + 4'd1;
        d0 <= 4'd0;
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - BCD time-of-day core with prescaler, 12/24h hours and run/pause/set control
module bcd_timekeeper
  import watch_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int HOUR_MODE = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_resume,
  input  logic       stop,
  input  logic       set_mode,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [3:0] hr1,
  output logic [3:0] hr0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic       pm,
  output logic       running,
  output logic       tick,
  output logic       daypass
);

  localparam bit   IS_12H  = (HOUR_MODE == HOUR_MODE_12);
  localparam int   PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam bcd_t RST_HR1 = IS_12H ? RST_HR1_12 : RST_HR1_24;
  localparam bcd_t RST_HR0 = IS_12H ? RST_HR0_12 : RST_HR0_24;

  tk_state_t     state;
  tk_state_t     state_nxt;
  logic [PW-1:0] presc;
  logic          advance;
  logic          set_sec;
  logic          set_min;
  logic          set_hr;
  logic          sec_carry;
  logic          min_carry;
  logic          hr_cascade;
  logic          hr_inc;
  bcd_t          hr1_nxt;
  bcd_t          hr0_nxt;
  logic          pm_flip;
  logic          day_wrap;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (stop) state_nxt = ST_PAUSE;
      ST_IDLE,
      ST_PAUSE: begin
        if (set_mode)          state_nxt = ST_SET;
        else if (start_resume) state_nxt = ST_RUN;
      end
      ST_SET:   if (!set_mode) state_nxt = ST_PAUSE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign advance = (state == ST_RUN) && (presc == PRESC_LAST);

  always_comb begin
    set_sec = 1'b0;
    set_min = 1'b0;
    set_hr  = 1'b0;
    if ((state == ST_SET) && set_inc) begin
      case (set_sel)
        SEL_SEC:  set_sec = 1'b1;
        SEL_MIN:  set_min = 1'b1;
        SEL_HR:   set_hr  = 1'b1;
        SEL_NONE: ;
        default:  ;
      endcase
    end
  end

  // Prescaler holds its count in PAUSE so a resumed second is not lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if ((state != ST_SET) && (state_nxt == ST_SET)) begin
      presc <= '0;
    end else if (state == ST_RUN) begin
      presc <= advance ? '0 : presc + PW'(1);
    end
  end

  bcd_mod_counter #(
    .MODULUS   (60),
    .RESET_VAL (RST_SEC)
  ) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (advance),
    .clear (set_sec),
    .d1    (sec1),
    .d0    (sec0),
    .carry (sec_carry)
  );

  bcd_mod_counter #(
    .MODULUS   (60),
    .RESET_VAL (RST_MIN)
  ) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_carry || set_min),
    .clear (1'b0),
    .d1    (min1),
    .d0    (min0),
    .carry (min_carry)
  );

  // sec_carry only exists in RUN, so a SET minute wrap never reaches the hours
  assign hr_cascade = sec_carry && min_carry;
  assign hr_inc     = hr_cascade || set_hr;

  always_comb begin
    hr1_nxt  = hr1;
    hr0_nxt  = hr0;
    pm_flip  = 1'b0;
    day_wrap = 1'b0;
    if (IS_12H) begin
      if ((hr1 == 4'd1) && (hr0 == 4'd2)) begin
        hr1_nxt = 4'd0;
        hr0_nxt = 4'd1;
      end else if ((hr1 == 4'd1) && (hr0 == 4'd1)) begin
        hr0_nxt  = 4'd2;
        pm_flip  = 1'b1;
        day_wrap = pm;
      end else if (hr0 == 4'd9) begin
        hr1_nxt = 4'd1;
        hr0_nxt = 4'd0;
      end else begin
        hr0_nxt = hr0 + 4'd1;
      end
    end else begin
      if ((hr1 == 4'd2) && (hr0 == 4'd3)) begin
        hr1_nxt  = 4'd0;
        hr0_nxt  = 4'd0;
        day_wrap = 1'b1;
      end else if (hr0 == 4'd9) begin
        hr1_nxt = hr1 + 4'd1;
        hr0_nxt = 4'd0;
      end else begin
        hr0_nxt = hr0 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr1 <= RST_HR1;
      hr0 <= RST_HR0;
      pm  <= 1'b0;
    end else if (hr_inc) begin
      hr1 <= hr1_nxt;
      hr0 <= hr0_nxt;
      if (pm_flip) pm <= ~pm;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      running <= 1'b0;
      tick    <= 1'b0;
      daypass <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      tick    <= advance;
      daypass <= hr_cascade && day_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - self-checking bench: four parameter variants against a seconds-of-day model
module tb_bcd_timekeeper;

  localparam int NDUT = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SET = 3;

  function automatic int td_of(input int i);
    return (i == 0) ? 4 : (i == 3) ? 8 : 1;
  endfunction

  function automatic int mode_of(input int i);
    return (i == 2) ? 12 : 24;
  endfunction

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_resume = 1'b0;
  logic       stop = 1'b0;
  logic       set_mode = 1'b0;
  logic [1:0] set_sel = 2'b11;
  logic       set_inc = 1'b0;

  logic [3:0] hr1 [NDUT];
  logic [3:0] hr0 [NDUT];
  logic [3:0] min1 [NDUT];
  logic [3:0] min0 [NDUT];
  logic [3:0] sec1 [NDUT];
  logic [3:0] sec0 [NDUT];
  logic       pm [NDUT];
  logic       running [NDUT];
  logic       tick [NDUT];
  logic       daypass [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bcd_timekeeper #(
      .TICK_DIV  (td_of(g)),
      .HOUR_MODE (mode_of(g))
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start_resume (start_resume),
      .stop         (stop),
      .set_mode     (set_mode),
      .set_sel      (set_sel),
      .set_inc      (set_inc),
      .hr1          (hr1[g]),
      .hr0          (hr0[g]),
      .min1         (min1[g]),
      .min0         (min0[g]),
      .sec1         (sec1[g]),
      .sec0         (sec0[g]),
      .pm           (pm[g]),
      .running      (running[g]),
      .tick         (tick[g]),
      .daypass      (daypass[g])
    );
  end

  // Model keeps time as seconds since midnight on a 24-hour scale
  typedef struct packed {
    logic [1:0] st;
    int         presc;
    int         sod;
    logic       tk;
    logic       day;
  } mdl_t;

  mdl_t m [NDUT];

  function automatic mdl_t mdl_reset();
    mdl_t n;
    n.st = 2'(M_IDLE);
    n.presc = 0;
    n.sod = 0;
    n.tk = 1'b0;
    n.day = 1'b0;
    return n;
  endfunction

  function automatic mdl_t step(input mdl_t c, input int td, input logic sr, input logic sp,
                                input logic sm, input logic [1:0] sel, input logic inc);
    mdl_t n;
    int h, mi, s;
    n = c;
    n.tk = 1'b0;
    n.day = 1'b0;
    h = c.sod / 3600;
    mi = (c.sod / 60) % 60;
    s = c.sod % 60;
    case (int'(c.st))
      M_RUN: begin
        if (c.presc + 1 == td) begin
          n.presc = 0;
          n.tk = 1'b1;
          n.day = (c.sod == 86399);
          n.sod = (c.sod + 1) % 86400;
        end else begin
          n.presc = c.presc + 1;
        end
        if (sp) n.st = 2'(M_PAUSE);
      end
      M_SET: begin
        if (inc) begin
          if (sel == 2'd0)      n.sod = h * 3600 + mi * 60;
          else if (sel == 2'd1) n.sod = h * 3600 + ((mi + 1) % 60) * 60 + s;
          else if (sel == 2'd2) n.sod = ((h + 1) % 24) * 3600 + mi * 60 + s;
        end
        if (!sm) n.st = 2'(M_PAUSE);
      end
      default: begin
        if (sm) begin
          n.st = 2'(M_SET);
          n.presc = 0;
        end else if (sr) begin
          n.st = 2'(M_RUN);
        end
      end
    endcase
    return n;
  endfunction

  function automatic logic [27:0] expect_out(input mdl_t c, input int mode);
    int h, hd, mi, s;
    logic p;
    h = c.sod / 3600;
    mi = (c.sod / 60) % 60;
    s = c.sod % 60;
    hd = h;
    p = 1'b0;
    if (mode == 12) begin
      p = (h >= 12);
      hd = (h % 12 == 0) ? 12 : h % 12;
    end
    return {4'(hd / 10), 4'(hd % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10),
            p, (int'(c.st) == M_RUN), c.tk, c.day};
  endfunction

  function automatic logic [27:0] actual_out(input int i);
    return {hr1[i], hr0[i], min1[i], min0[i], sec1[i], sec0[i], pm[i], running[i], tick[i], daypass[i]};
  endfunction

  function automatic logic [23:0] time_of(input int i);
    return {hr1[i], hr0[i], min1[i], min0[i], sec1[i], sec0[i]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDUT; i++) m[i] <= mdl_reset();
    end else begin
      for (int i = 0; i < NDUT; i++)
        m[i] <= step(m[i], td_of(i), start_resume, stop, set_mode, set_sel, set_inc);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      n_cmp++;
      if (actual_out(i) !== expect_out(m[i], mode_of(i))) begin
        n_bad++;
        $display("FAIL model dut%0d t=%0t got %h want %h (hhmmss,pm,run,tick,day)",
                 i, $time, actual_out(i), expect_out(m[i], mode_of(i)));
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start_resume = 1'b1;
    cyc(1);
    start_resume = 1'b0;
  endtask

  task automatic inc_pulses(input logic [1:0] sel, input int n);
    set_sel = sel;
    repeat (n) begin
      set_inc = 1'b1;
      cyc(1);
      set_inc = 1'b0;
      cyc(1);
    end
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_time_24", time_of(0), 24'h000000);
    check("rst_time_12", time_of(2), 24'h120000);
    check("rst_pm_12", pm[2], 0);
    check("rst_running", running[0], 0);

    // Free run from a cleared prescaler
    pulse_start();
    check("run_started", running[0], 1);
    cyc(3);
    check("td4_no_tick_3", tick[0], 0);
    cyc(1);
    check("td4_tick_4", tick[0], 1);
    check("td4_first_sec", time_of(0), 24'h000001);
    cyc(236);
    check("td4_240cyc", time_of(0), 24'h000100);
    check("td4_240_tick", tick[0], 1);
    check("td1_240cyc", time_of(1), 24'h000400);
    check("td1_12h_240cyc", time_of(2), 24'h120400);
    check("td8_240cyc", time_of(3), 24'h000030);

    // Pause with five counts held in the TICK_DIV=8 prescaler
    cyc(4);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("paused", running[3], 0);
    cyc(20);
    check("frozen", time_of(3), 24'h000030);
    pulse_start();
    cyc(1);
    check("resume_tick_m1", tick[3], 0);
    cyc(1);
    check("resume_tick_m2", tick[3], 0);
    cyc(1);
    check("resume_tick_m3", tick[3], 1);
    check("resume_time", time_of(3), 24'h000031);
    start_resume = 1'b1;
    stop = 1'b1;
    cyc(1);
    start_resume = 1'b0;
    stop = 1'b0;
    check("stop_wins", running[0], 0);

    // SET from a fresh reset
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(1);
    set_mode = 1'b1;
    cyc(1);
    inc_pulses(2'b01, 59);
    check("set_min59", time_of(3), 24'h005900);
    inc_pulses(2'b01, 1);
    check("set_min_wrap", time_of(3), 24'h000000);
    check("set_min_wrap_12", time_of(2), 24'h120000);
    start_resume = 1'b1;
    cyc(1);
    start_resume = 1'b0;
    check("start_in_set", running[0], 0);
    cyc(1);
    inc_pulses(2'b11, 2);
    inc_pulses(2'b01, 59);
    inc_pulses(2'b10, 23);
    check("set_235900", time_of(1), 24'h235900);
    check("set_115900pm", time_of(2), 24'h115900);
    check("set_pm", pm[2], 1);
    set_mode = 1'b0;
    cyc(1);

    // Midnight rollover
    pulse_start();
    cyc(58);
    check("t_235958", time_of(1), 24'h235958);
    cyc(1);
    check("t_235959", time_of(1), 24'h235959);
    check("no_day_early", daypass[1], 0);
    cyc(1);
    check("t_000000", time_of(1), 24'h000000);
    check("day_24", daypass[1], 1);
    check("day_tick_24", tick[1], 1);
    check("t12_midnight", time_of(2), 24'h120000);
    check("pm_midnight", pm[2], 0);
    check("day_12", daypass[2], 1);
    cyc(1);
    check("day_one_cycle", daypass[1], 0);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("t_000002", time_of(1), 24'h000002);

    // Noon and 12 -> 1 in 12-hour mode
    set_mode = 1'b1;
    cyc(1);
    inc_pulses(2'b00, 1);
    check("sec_clear", time_of(1), 24'h000000);
    inc_pulses(2'b01, 59);
    inc_pulses(2'b10, 11);
    check("set_115900am", time_of(2), 24'h115900);
    check("set_am", pm[2], 0);
    set_mode = 1'b0;
    cyc(1);
    pulse_start();
    cyc(59);
    check("t12_115959", time_of(2), 24'h115959);
    cyc(1);
    check("t12_noon", time_of(2), 24'h120000);
    check("pm_noon", pm[2], 1);
    check("no_day_noon", daypass[2], 0);
    cyc(3599);
    check("t12_125959", time_of(2), 24'h125959);
    cyc(1);
    check("t12_010000", time_of(2), 24'h010000);
    check("pm_kept", pm[2], 1);
    check("t24_130000", time_of(1), 24'h130000);

    // Async reset mid-run at 07:30:15
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    set_mode = 1'b1;
    cyc(1);
    inc_pulses(2'b10, 18);
    inc_pulses(2'b01, 30);
    inc_pulses(2'b00, 1);
    set_mode = 1'b0;
    cyc(1);
    pulse_start();
    cyc(15);
    check("t_073015", time_of(1), 24'h073015);
    check("run_073015", running[1], 1);
    #1 reset = 1'b1;
    #1;
    check("arst_time_24", time_of(1), 24'h000000);
    check("arst_time_12", time_of(2), 24'h120000);
    check("arst_running", running[1], 0);
    check("arst_tick", tick[1], 0);
    check("arst_day", daypass[1], 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Async reset mid-SET
    set_mode = 1'b1;
    cyc(1);
    inc_pulses(2'b01, 5);
    check("set_000500", time_of(1), 24'h000500);
    #1 reset = 1'b1;
    #1;
    check("arst_set_time", time_of(1), 24'h000000);
    check("arst_set_time12", time_of(2), 24'h120000);
    check("arst_set_run", running[1], 0);
    cyc(1);
    reset = 1'b0;
    set_mode = 1'b0;
    cyc(2);
    check("idle_after_rst", running[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
